// File: rtl/mem_ctrl_param.sv
// Parametrised line memory controller: queued read, byte-masked
// word RMW and full-line write, one in-order response per request.
module mem_ctrl_param #(
   parameter int LINE_W = 128,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 8,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 2,
   parameter int QDEPTH = 4
) (
   input  logic                mclk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [LINE_W-1:0]   req_wdata,
   input  logic [WORD_W/8-1:0] req_wmask,
   input  logic [ID_W-1:0]     req_id,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [1:0]          rsp_op,
   output logic [ID_W-1:0]     rsp_id,
   output logic [LINE_W-1:0]   rsp_data,
   output logic                rsp_err,
   output logic [ADDR_W-1:0]   mem_addr_sel,
   output logic [LINE_W-1:0]   mem_wdat,
   input  logic [LINE_W-1:0]   mem_rdat,
   output logic                mem_en,
   output logic                mem_we,
   output logic                mem_re
);
   localparam int LB   = LINE_W / 8;
   localparam int WBY  = WORD_W / 8;
   localparam int WSH  = $clog2(WBY);
   localparam int NW   = LINE_W / WORD_W;
   localparam int KW   = (NW > 1) ? $clog2(NW) : 1;
   localparam int PW   = $clog2(QDEPTH);
   localparam int MAXL = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CW   = $clog2(MAXL + 1);

   typedef struct packed {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic [WBY-1:0]    wmask;
      logic [ID_W-1:0]   id;
   } req_t;

   typedef enum logic [2:0] {
      IDLE, RD_ISSUE_WAIT, MERGE, WR_HOLD, RESP
   } state_t;

   req_t          fifo_q [QDEPTH];
   req_t          head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count, count_d;
   logic          push, pop;

   state_t            state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [LINE_W-1:0] line_q, line_d, merged;
   logic [WORD_W-1:0] cur_word, word_d;
   logic [WBY-1:0]    cur_mask, mask_d;
   logic [KW-1:0]     cur_k, k_d;

   logic              rvalid_d, rerr_d;
   logic [1:0]        rop_d;
   logic [ID_W-1:0]   rid_d;
   logic [LINE_W-1:0] rdata_d, wdat_d;
   logic [ADDR_W-1:0] addr_d;
   logic              en_d, we_d, re_d;

   assign push    = req_valid && req_ready;
   assign head    = fifo_q[rd_ptr];
   assign count_d = count + (PW+1)'(push) - (PW+1)'(pop);

   always_ff @(posedge mclk) begin
      if (push) begin
         fifo_q[wr_ptr] <= {req_op, req_addr, req_wdata,
                            req_wmask, req_id};
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         req_ready <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count     <= count_d;
         req_ready <= (count_d != (PW+1)'(QDEPTH));
      end
   end

   // Only the addressed word's enabled bytes are replaced.
   always_comb begin
      merged = line_q;
      for (int b = 0; b < WBY; b++) begin
         if (cur_mask[b]) begin
            merged[int'(cur_k)*WORD_W + b*8 +: 8] = cur_word[b*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      line_d   = line_q;
      word_d   = cur_word;
      mask_d   = cur_mask;
      k_d      = cur_k;
      rvalid_d = rsp_valid;
      rop_d    = rsp_op;
      rid_d    = rsp_id;
      rdata_d  = rsp_data;
      rerr_d   = rsp_err;
      addr_d   = mem_addr_sel;
      wdat_d   = mem_wdat;
      en_d     = mem_en;
      we_d     = mem_we;
      re_d     = mem_re;
      pop      = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               rop_d   = head.op;
               rid_d   = head.id;
               rerr_d  = 1'b0;
               rdata_d = '0;
               addr_d  = head.addr & ~ADDR_W'(LB - 1);
               word_d  = head.wdata[WORD_W-1:0];
               mask_d  = head.wmask;
               k_d     = KW'((head.addr >> WSH) & ADDR_W'(NW - 1));
               if (head.op == 2'd3) begin
                  rerr_d  = 1'b1;
                  state_d = RESP;
               end else if (head.op == 2'd2) begin
                  wdat_d  = head.wdata;
                  en_d    = 1'b1;
                  we_d    = 1'b1;
                  cnt_d   = CW'(WR_LAT);
                  state_d = WR_HOLD;
               end else begin
                  en_d    = 1'b1;
                  re_d    = 1'b1;
                  cnt_d   = CW'(RD_LAT);
                  state_d = RD_ISSUE_WAIT;
               end
            end
         end
         RD_ISSUE_WAIT: begin
            if (cnt == CW'(1)) begin
               cnt_d = '0;
               en_d  = 1'b0;
               re_d  = 1'b0;
               if (rsp_op == 2'd0) begin
                  rdata_d  = mem_rdat;
                  rvalid_d = 1'b1;
                  state_d  = RESP;
               end else begin
                  line_d  = mem_rdat;
                  state_d = MERGE;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         MERGE: begin
            wdat_d  = merged;
            en_d    = 1'b1;
            we_d    = 1'b1;
            re_d    = 1'b0;
            cnt_d   = CW'(WR_LAT);
            state_d = WR_HOLD;
         end
         WR_HOLD: begin
            if (cnt == '0) begin
               en_d     = 1'b0;
               we_d     = 1'b0;
               rdata_d  = mem_wdat;
               rvalid_d = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         RESP: begin
            // An illegal op enters with valid low and raises it here.
            if (!rsp_valid) begin
               rvalid_d = 1'b1;
            end else if (rsp_ready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         line_q       <= '0;
         cur_word     <= '0;
         cur_mask     <= '0;
         cur_k        <= '0;
         rsp_valid    <= 1'b0;
         rsp_op       <= '0;
         rsp_id       <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         mem_addr_sel <= '0;
         mem_wdat     <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_re       <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         line_q       <= line_d;
         cur_word     <= word_d;
         cur_mask     <= mask_d;
         cur_k        <= k_d;
         rsp_valid    <= rvalid_d;
         rsp_op       <= rop_d;
         rsp_id       <= rid_d;
         rsp_data     <= rdata_d;
         rsp_err      <= rerr_d;
         mem_addr_sel <= addr_d;
         mem_wdat     <= wdat_d;
         mem_en       <= en_d;
         mem_we       <= we_d;
         mem_re       <= re_d;
      end
   end
endmodule

// File: tb/tb_mem_ctrl_param.sv
// Bench for mem_ctrl_param: default 128-bit instance plus a 256-bit
// instance, each with a behavioural memory and an expected-response queue.
module tb_mem_ctrl_param;
   localparam int LW  = 128;
   localparam int RL  = 2;
   localparam int WL  = 2;
   localparam int LW2 = 256;
   localparam int RL2 = 3;
   localparam int WL2 = 1;

   localparam logic [127:0] L1   = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] A4   = {4{32'hAAAAAAAA}};
   localparam logic [127:0] RMW1 = 128'hAAAAAAAA_AA22AA44_AAAAAAAA_AAAAAAAA;
   localparam logic [127:0] RMW3 = 128'hDEADBEEF_AA22AA44_AAAAAAAA_AAAAAAAA;
   localparam logic [255:0] W1   =
      256'h0011223344556677_8899AABBCCDDEEFF_0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [255:0] A8   = {8{32'hAAAAAAAA}};
   localparam logic [255:0] WRMW =
      256'hAAAAAAAAAAAAAAAA_AA22AA44AA66AA88_AAAAAAAAAAAAAAAA_AAAAAAAAAAAAAAAA;

   typedef struct packed {
      logic [1:0]   op;
      logic [7:0]   id;
      logic [255:0] data;
      logic         err;
   } rsp_t;

   logic mclk = 1'b0;
   logic rst  = 1'b1;
   always #5 mclk = ~mclk;

   logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]    req_op, rsp_op;
   logic [31:0]   req_addr, mem_addr_sel;
   logic [LW-1:0] req_wdata, rsp_data, mem_wdat, mem_rdat;
   logic [3:0]    req_wmask;
   logic [7:0]    req_id, rsp_id;
   logic          mem_en, mem_we, mem_re;

   logic           w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready;
   logic           w_rsp_err;
   logic [1:0]     w_req_op, w_rsp_op;
   logic [31:0]    w_req_addr, w_mem_addr_sel;
   logic [LW2-1:0] w_req_wdata, w_rsp_data, w_mem_wdat, w_mem_rdat;
   logic [7:0]     w_req_wmask, w_req_id, w_rsp_id;
   logic           w_mem_en, w_mem_we, w_mem_re;

   mem_ctrl_param #(
      .LINE_W(LW), .WORD_W(32), .ADDR_W(32), .ID_W(8),
      .RD_LAT(RL), .WR_LAT(WL), .QDEPTH(4)
   ) dut (
      .mclk(mclk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask), .req_id(req_id),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_op(rsp_op), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_addr_sel(mem_addr_sel), .mem_wdat(mem_wdat),
      .mem_rdat(mem_rdat), .mem_en(mem_en),
      .mem_we(mem_we), .mem_re(mem_re)
   );

   mem_ctrl_param #(
      .LINE_W(LW2), .WORD_W(64), .ADDR_W(32), .ID_W(8),
      .RD_LAT(RL2), .WR_LAT(WL2), .QDEPTH(4)
   ) dut_w (
      .mclk(mclk), .rst(rst),
      .req_valid(w_req_valid), .req_ready(w_req_ready),
      .req_op(w_req_op), .req_addr(w_req_addr),
      .req_wdata(w_req_wdata), .req_wmask(w_req_wmask), .req_id(w_req_id),
      .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
      .rsp_op(w_rsp_op), .rsp_id(w_rsp_id),
      .rsp_data(w_rsp_data), .rsp_err(w_rsp_err),
      .mem_addr_sel(w_mem_addr_sel), .mem_wdat(w_mem_wdat),
      .mem_rdat(w_mem_rdat), .mem_en(w_mem_en),
      .mem_we(w_mem_we), .mem_re(w_mem_re)
   );

   // Memory models: data only valid once mem_re has been held RD_LAT cycles
   logic [LW-1:0]  mem_n [64];
   logic [LW2-1:0] mem_w [64];
   int re_n   = 0;
   int re_w   = 0;
   int cyc    = 0;
   int en_cnt = 0;

   always @(posedge mclk) begin
      cyc <= cyc + 1;
      if (mem_en) en_cnt <= en_cnt + 1;
      if (mem_en && mem_we) mem_n[mem_addr_sel[9:4]] <= mem_wdat;
      if (w_mem_en && w_mem_we) mem_w[w_mem_addr_sel[10:5]] <= w_mem_wdat;
      re_n <= mem_re ? re_n + 1 : 0;
      re_w <= w_mem_re ? re_w + 1 : 0;
   end

   assign mem_rdat = (mem_re && re_n >= RL - 1) ?
                     mem_n[mem_addr_sel[9:4]] : {LW/16{16'hDEAD}};
   assign w_mem_rdat = (w_mem_re && re_w >= RL2 - 1) ?
                       mem_w[w_mem_addr_sel[10:5]] : {LW2/16{16'hDEAD}};

   rsp_t exp_q[$];
   rsp_t wexp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic rsp_t mk(input logic [1:0] op, input logic [7:0] id,
                               input logic [255:0] d, input logic err);
      rsp_t r;
      r.op   = op;
      r.id   = id;
      r.data = d;
      r.err  = err;
      return r;
   endfunction

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic send(input bit wide, input logic [1:0] op,
                       input logic [31:0] addr, input logic [255:0] wd,
                       input logic [7:0] mask, input logic [7:0] id,
                       output int acc);
      int n = 0;
      if (wide) begin
         w_req_op = op; w_req_addr = addr; w_req_wdata = wd;
         w_req_wmask = mask; w_req_id = id; w_req_valid = 1'b1;
      end else begin
         req_op = op; req_addr = addr; req_wdata = wd[LW-1:0];
         req_wmask = mask[3:0]; req_id = id; req_valid = 1'b1;
      end
      while (!(wide ? w_req_ready : req_ready) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout id=%0h got ready=0 need 1", id);
      end
      step();
      acc = cyc;
      req_valid = 1'b0;
      w_req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input bit wide, output rsp_t got, output int at);
      int n = 0;
      while (!(wide ? w_rsp_valid : rsp_valid) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_timeout wide=%0d got valid=0 need 1", wide);
      end
      at = cyc;
      if (wide) got = mk(w_rsp_op, w_rsp_id, w_rsp_data, w_rsp_err);
      else      got = mk(rsp_op, rsp_id, 256'(rsp_data), rsp_err);
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_op, rsp_id, rsp_data, rsp_err,
           mem_addr_sel, mem_wdat, mem_en, mem_we, mem_re} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs got nonzero need all 0 (rsp_data=%h)",
                  rsp_data);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready got %b need 1", req_ready);
      end
      n_cmp++;
      if (w_req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready_w got %b need 1", w_req_ready);
      end
   endtask

   task automatic test_line_rw();
      rsp_t got, e;
      int acc, at;
      send(0, 2'd2, 32'h40, 256'(L1), 8'h0, 8'h01, acc);
      exp_q.push_back(mk(2'd2, 8'h01, 256'(L1), 1'b0));
      wait_rsp(0, got, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL line_wr_rsp got %h need %h", got, e);
      end
      n_cmp++;
      if (at - acc !== 2 + WL) begin
         n_bad++; $display("FAIL line_wr_lat got %0d need %0d", at - acc, 2 + WL);
      end
      n_cmp++;
      if (mem_n[4] !== L1) begin
         n_bad++; $display("FAIL line_wr_mem got %h need %h", mem_n[4], L1);
      end
      send(0, 2'd0, 32'h4C, '0, 8'h0, 8'h02, acc);
      exp_q.push_back(mk(2'd0, 8'h02, 256'(L1), 1'b0));
      wait_rsp(0, got, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL line_rd_rsp got %h need %h", got, e);
      end
      n_cmp++;
      if (at - acc !== 1 + RL) begin
         n_bad++; $display("FAIL line_rd_lat got %0d need %0d", at - acc, 1 + RL);
      end
   endtask

   task automatic test_rmw();
      rsp_t got, e;
      int acc, at;
      send(0, 2'd2, 32'h80, 256'(A4), 8'h0, 8'h03, acc);
      exp_q.push_back(mk(2'd2, 8'h03, 256'(A4), 1'b0));
      wait_rsp(0, got, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL rmw_preload got %h need %h", got, e);
      end
      send(0, 2'd1, 32'h88, 256'(32'h11223344), 8'h5, 8'h04, acc);
      exp_q.push_back(mk(2'd1, 8'h04, 256'(RMW1), 1'b0));
      wait_rsp(0, got, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL rmw_word2 got %h need %h", got, e);
      end
      n_cmp++;
      if (at - acc !== 3 + RL + WL) begin
         n_bad++; $display("FAIL rmw_lat got %0d need %0d", at - acc, 3 + RL + WL);
      end
      n_cmp++;
      if (mem_n[8] !== RMW1) begin
         n_bad++; $display("FAIL rmw_mem got %h need %h", mem_n[8], RMW1);
      end
      send(0, 2'd1, 32'h84, 256'(32'hFFFFFFFF), 8'h0, 8'h05, acc);
      exp_q.push_back(mk(2'd1, 8'h05, 256'(RMW1), 1'b0));
      wait_rsp(0, got, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL rmw_mask0 got %h need %h", got, e);
      end
      send(0, 2'd1, 32'h8F, 256'(32'hDEADBEEF), 8'hF, 8'h06, acc);
      exp_q.push_back(mk(2'd1, 8'h06, 256'(RMW3), 1'b0));
      wait_rsp(0, got, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL rmw_word3 got %h need %h", got, e);
      end
   endtask

   task automatic test_back_to_back();
      rsp_t got, e;
      int acc = 0;
      int at;
      logic rdy;
      rsp_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         req_op = 2'd0;
         req_addr = (acc % 2 == 1) ? 32'h80 : 32'h40;
         req_id = 8'(acc);
         req_valid = (acc < 6);
         rdy = req_ready;
         step();
         if (rdy && req_valid) begin
            exp_q.push_back(mk(2'd0, 8'(acc),
                               256'((acc % 2 == 1) ? RMW3 : L1), 1'b0));
            acc++;
         end
      end
      n_cmp++;
      if (acc !== 5) begin
         n_bad++; $display("FAIL b2b_accepts got %0d need 5", acc);
      end
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_bad++; $display("FAIL b2b_full_ready got %b need 0", req_ready);
      end
      exp_q.push_back(mk(2'd0, 8'h05, 256'(RMW3), 1'b0));
      rsp_ready = 1'b1;
      fork
         begin
            int n = 0;
            while (!req_ready && n < 50) begin
               step();
               n++;
            end
            step();
            req_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 6; i++) begin
               wait_rsp(0, got, at);
               e = exp_q.pop_front();
               n_cmp++;
               if (got !== e) begin
                  n_bad++; $display("FAIL b2b_rsp%0d got %h need %h", i, got, e);
               end
            end
         end
      join
      repeat (8) step();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL b2b_extra_rsp got id=%0h need none", rsp_id);
      end
   endtask

   task automatic test_illegal();
      rsp_t got, e;
      int acc, at, e0;
      e0 = en_cnt;
      send(0, 2'd3, 32'h123, '0, 8'h0, 8'h5A, acc);
      exp_q.push_back(mk(2'd3, 8'h5A, '0, 1'b1));
      wait_rsp(0, got, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL illegal_rsp got %h need %h", got, e);
      end
      n_cmp++;
      if (at - acc !== 2) begin
         n_bad++; $display("FAIL illegal_lat got %0d need 2", at - acc);
      end
      n_cmp++;
      if (en_cnt - e0 !== 0) begin
         n_bad++; $display("FAIL illegal_mem_en got %0d cycles need 0", en_cnt - e0);
      end
   endtask

   task automatic test_reset_mid();
      rsp_t got, e;
      int acc, at;
      int n = 0;
      send(0, 2'd1, 32'h80, 256'(32'h55555555), 8'hF, 8'h77, acc);
      while (!mem_we && n < 50) begin
         step();
         n++;
      end
      n_cmp++;
      if (mem_we !== 1'b1) begin
         n_bad++; $display("FAIL rst_mid_hold got we=%b need 1", mem_we);
      end
      rst = 1'b1;
      step();
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_op, rsp_id, rsp_data, rsp_err,
           mem_addr_sel, mem_wdat, mem_en, mem_we, mem_re} !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs got en=%b we=%b valid=%b need all 0",
                  mem_en, mem_we, rsp_valid);
      end
      rst = 1'b0;
      step();
      send(0, 2'd0, 32'h4C, '0, 8'h0, 8'h78, acc);
      exp_q.push_back(mk(2'd0, 8'h78, 256'(L1), 1'b0));
      wait_rsp(0, got, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL rst_mid_next got %h need %h", got, e);
      end
   endtask

   task automatic test_wide();
      rsp_t got, e;
      int acc, at;
      send(1, 2'd2, 32'h40, W1, 8'h0, 8'h21, acc);
      wexp_q.push_back(mk(2'd2, 8'h21, W1, 1'b0));
      wait_rsp(1, got, at);
      e = wexp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL wide_wr_rsp got %h need %h", got, e);
      end
      n_cmp++;
      if (at - acc !== 2 + WL2) begin
         n_bad++; $display("FAIL wide_wr_lat got %0d need %0d", at - acc, 2 + WL2);
      end
      send(1, 2'd0, 32'h58, '0, 8'h0, 8'h22, acc);
      wexp_q.push_back(mk(2'd0, 8'h22, W1, 1'b0));
      wait_rsp(1, got, at);
      e = wexp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL wide_rd_rsp got %h need %h", got, e);
      end
      n_cmp++;
      if (at - acc !== 1 + RL2) begin
         n_bad++; $display("FAIL wide_rd_lat got %0d need %0d", at - acc, 1 + RL2);
      end
      send(1, 2'd2, 32'h80, A8, 8'h0, 8'h23, acc);
      wexp_q.push_back(mk(2'd2, 8'h23, A8, 1'b0));
      wait_rsp(1, got, at);
      e = wexp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL wide_preload got %h need %h", got, e);
      end
      send(1, 2'd1, 32'h90, 256'(64'h1122334455667788), 8'h55, 8'h24, acc);
      wexp_q.push_back(mk(2'd1, 8'h24, WRMW, 1'b0));
      wait_rsp(1, got, at);
      e = wexp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++; $display("FAIL wide_rmw got %h need %h", got, e);
      end
      n_cmp++;
      if (at - acc !== 3 + RL2 + WL2) begin
         n_bad++;
         $display("FAIL wide_rmw_lat got %0d need %0d", at - acc, 3 + RL2 + WL2);
      end
      n_cmp++;
      if (mem_w[4] !== WRMW) begin
         n_bad++; $display("FAIL wide_rmw_mem got %h need %h", mem_w[4], WRMW);
      end
   endtask

   initial begin
      req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      req_wmask = '0; req_id = '0; rsp_ready = 1'b1;
      w_req_valid = 1'b0; w_req_op = '0; w_req_addr = '0; w_req_wdata = '0;
      w_req_wmask = '0; w_req_id = '0; w_rsp_ready = 1'b1;
      test_reset();
      test_line_rw();
      test_rmw();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish need finish before 200000");
      $fatal(1);
   end
endmodule

// File: doc/mem_ctrl_param.md
Name: mem_ctrl_param

Overview:
Parametrised single-clock memory controller that replaces the fixed 128-bit read/RMW memory front end.
- Accepts queued requests on a valid/ready interface: line read, byte-masked word write (read-modify-write at any word offset), full-line write.
- Returns one response per request, in order.
- Sits between the NOC-stop adapter and the synchronous memory macro.
- Read/write latencies and the queue depth are configurable.

Parameters:
LINE_W, 128, memory line width in bits (power of 2, ≥ WORD_W)
WORD_W, 32, word width for word writes (power of 2, multiple of 8)
ADDR_W, 32, byte address width
ID_W, 8, request tag width
RD_LAT, 2, cycles from read issue to mem_rdat valid (≥1)
WR_LAT, 2, cycles mem_we is held per write (≥1)
QDEPTH, 4, request queue entries (power of 2, ≥2)

Ports:
mclk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  queue can accept
req_op  in  2  0 read, 1 word write, 2 line write, 3 illegal
req_addr  in  ADDR_W  byte address
req_wdata  in  LINE_W  line data; word write uses bits [WORD_W-1:0]
req_wmask  in  WORD_W/8  byte enables for word write
req_id  in  ID_W  tag, echoed in response
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_op  out  2  echo of req_op
rsp_id  out  ID_W  echo of req_id
rsp_data  out  LINE_W  read data, or line as written for writes
rsp_err  out  1  illegal op
mem_addr_sel  out  ADDR_W  line-aligned address
mem_wdat  out  LINE_W  write data
mem_rdat  in  LINE_W  read data
mem_en  out  1  memory enable
mem_we  out  1  write enable
mem_re  out  1  read enable

Behaviour:
Reset:
- At a rst edge, every output goes to 0, the queue is flushed and the FSM returns to IDLE.
- An in-flight request is dropped with no response. Memory is left however the interrupted op left it.
- req_ready goes to 1 on the first edge after rst deasserts.

Address arithmetic:
- OB = log2(LINE_W/8), WB = log2(WORD_W/8).
- mem_addr_sel = req_addr with bits [OB-1:0] zeroed.
- Word index = req_addr[OB-1:WB]. Bits [WB-1:0] are ignored.

Queue:
- FIFO of QDEPTH entries; req_ready = !full, registered.
- Accept on a mclk edge with req_valid && req_ready.
- Enqueue and dequeue on the same edge are allowed when not full.

FSM states: IDLE, RD_ISSUE_WAIT, MERGE, WR_HOLD, RESP.
- IDLE: if the queue is non-empty and RESP is free, pop the head.
  - Op 0 or 1: drive mem_en=1, mem_re=1, mem_we=0, mem_addr_sel; go to RD_ISSUE_WAIT with counter=RD_LAT.
  - Op 2: mem_wdat=req_wdata, mem_en=1, mem_we=1, mem_re=0; go to WR_HOLD with counter=WR_LAT.
  - Op 3: no memory access; go to RESP with rsp_err=1 and rsp_data=0.
- RD_ISSUE_WAIT: decrement the counter. On the edge where it reaches 0, sample mem_rdat.
  - Op 0: rsp_data=mem_rdat; drop mem_en/mem_re; go to RESP.
  - Op 1: go to MERGE with the line held.
- MERGE (1 cycle): for each byte b of word index k, take wdata byte b if wmask[b]=1, else the old byte. All other words are unchanged.
  - Drive mem_wdat=merged, mem_re=0, mem_we=1, mem_en=1; go to WR_HOLD with counter=WR_LAT.
- WR_HOLD: hold mem_addr_sel, mem_wdat and mem_we stable for WR_LAT cycles. Then drop mem_en/mem_we, set rsp_data=written line, go to RESP.
- RESP: rsp_valid=1 with all rsp_* stable until an edge with rsp_ready=1.
  - On that edge, clear rsp_valid and go to IDLE.
  - The next pop may happen on the following edge.
  - mem_en is low for ≥1 cycle between consecutive operations.

Latency (empty queue, rsp_ready=1):
- Read: rsp_valid visible after edge A+1+RD_LAT, where A is the accept edge.
- Word write: A+3+RD_LAT+WR_LAT.
- Line write: A+2+WR_LAT.
- Illegal: A+2.

Ordering and ID: responses are strictly in acceptance order. The ID is opaque and not checked for uniqueness.

Boundaries:
- Full queue with req_valid held: the request waits, with no loss or duplication.
- rsp_ready low for N cycles: the FSM stalls in RESP, the queue still fills to QDEPTH.
- wmask=0 on a word write: the RMW still executes and the line is rewritten unchanged.

Test Plan:
- Reset, write line addr 0x40 data 0x0123..CDEF (op2), read 0x4C → rsp_data equals the written line; read latency is exactly 1+RD_LAT edges after accept.
- Preload 0x80 with 0xAAAA_AAAA×4; word write addr 0x88 data 0x1122_3344 mask 4'b0101 → memory line = 0xAAAAAAAA_AA22AA44_AAAAAAAA_AAAAAAAA; rsp_data matches.
- Issue 6 back-to-back reads, QDEPTH=4, rsp_ready tied low → req_ready drops after 5 accepts (4 queued plus 1 in RESP); release rsp_ready → 6 responses in order, IDs 0..5.
- op=3 id=0x5A → rsp_err=1, rsp_id=0x5A, mem_en never asserted.
- Assert rst during WR_HOLD of a word write → all outputs 0 next edge, no response ever for that ID, the next request is served normally.
- Rerun the first two scenarios with LINE_W=256, WORD_W=64, RD_LAT=3, WR_LAT=1 → correct word index from addr bits [4:3], latencies rescale.
